// File: rtl/muldiv_sched_pkg.sv
// Shared definitions for the M-extension scheduler.
// Holds the req_op encodings, the scheduler state encoding and the
// multiplier signedness controls (bit 1 = multiplicand signed,
// bit 0 = multiplier signed).
package muldiv_sched_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  localparam logic [1:0] MS_SS = 2'b11;
  localparam logic [1:0] MS_SU = 2'b10;
  localparam logic [1:0] MS_UU = 2'b00;

endpackage : muldiv_sched_pkg

// File: rtl/muldiv_special_case.sv
// Combinational detection of the RISC-V divide corner cases that complete
// without the divider: divide-by-zero and signed overflow, for both the full
// width and the 32-bit (*W) forms.
// Ports:
//   op      - req_op encoding (only divide ops, op[2]=1, can hit)
//   w       - 32-bit variant; operands are taken from bits [31:0]
//   src1    - dividend
//   src2    - divisor
//   hit     - op is a divide special case
//   result  - architecturally defined result when hit is set
module muldiv_special_case
  import muldiv_sched_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      op,
  input  logic            w,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            hit,
  output logic [XLEN-1:0] result
);

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
    return {{(XLEN-32){x[31]}}, x};
  endfunction

  logic            is_div;
  logic            is_signed;
  logic            is_rem;
  logic            div_zero;
  logic            ovf;
  logic [XLEN-1:0] src1_ext;

  always_comb begin
    is_div    = op[2];
    is_signed = ~op[0];
    is_rem    = op[1];
    src1_ext  = w ? sext32(src1[31:0]) : src1;
    div_zero  = w ? (src2[31:0] == 32'd0) : (src2 == '0);
    // Most-negative / -1 only overflows for the signed forms.
    if (w) begin
      ovf = (src1[31:0] == 32'h8000_0000) && (src2[31:0] == 32'hFFFF_FFFF);
    end else begin
      ovf = (src1 == {1'b1, {(XLEN-1){1'b0}}}) && (src2 == '1);
    end
    ovf = ovf & is_signed;
    hit = is_div & (div_zero | ovf);

    result = '0;
    if (div_zero) begin
      result = is_rem ? src1_ext : '1;
    end else if (ovf) begin
      // Quotient equals the (sign-extended) dividend, remainder is zero.
      result = is_rem ? '0 : src1_ext;
    end
  end

endmodule : muldiv_special_case

// File: rtl/muldiv_sched.sv
// Sequencer between EX and the shared iterative multiplier/divider.
// One op at a time: accept on req_valid/req_ready, register operands,
// handshake with the selected unit, wait for its out_valid, select and
// sign-extend the result, hold it on resp_valid/resp_ready.
// Divide corner cases complete locally when FAST_PATH is set.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   flush             - cancel any in-flight op
//   req_*             - request port (op, w, operands, valid/ready)
//   resp_*            - response port (data, valid/ready)
//   busy              - scheduler not idle
//   mul_* / multiplicand / multiplier / mulw - multiplier interface
//   div_* / dividend / divisor / divw / quotient / remainder - divider interface
module muldiv_sched
  import muldiv_sched_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter bit FAST_PATH = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic            req_w,
  input  logic [XLEN-1:0] req_src1,
  input  logic [XLEN-1:0] req_src2,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            busy,
  output logic            mul_valid,
  input  logic            mul_ready,
  output logic            mulw,
  output logic [1:0]      mul_signed,
  output logic [XLEN-1:0] multiplicand,
  output logic [XLEN-1:0] multiplier,
  output logic            mul_flush,
  input  logic            mul_out_valid,
  input  logic [XLEN-1:0] mul_hi,
  input  logic [XLEN-1:0] mul_lo,
  output logic            div_valid,
  input  logic            div_ready,
  output logic            divw,
  output logic            div_signed,
  output logic [XLEN-1:0] dividend,
  output logic [XLEN-1:0] divisor,
  output logic            div_flush,
  input  logic            div_out_valid,
  input  logic [XLEN-1:0] quotient,
  input  logic [XLEN-1:0] remainder
);

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
    return {{(XLEN-32){x[31]}}, x};
  endfunction

  state_e          state_q;
  state_e          state_d;
  logic [2:0]      op_q;
  logic            w_q;
  logic [XLEN-1:0] src1_q;
  logic [XLEN-1:0] src2_q;
  logic [XLEN-1:0] resp_data_q;

  logic            sc_hit;
  logic [XLEN-1:0] sc_result;
  logic            accept;
  logic            fast_done;
  logic            is_div_q;
  logic            unit_ready;
  logic            unit_out_valid;
  logic            capture;
  logic [XLEN-1:0] raw_result;
  logic [XLEN-1:0] sel_result;

  // Corner-case check runs on the incoming request so a hit can go
  // straight from IDLE to DONE.
  muldiv_special_case #(
    .XLEN (XLEN)
  ) u_special (
    .op     (req_op),
    .w      (req_w),
    .src1   (req_src1),
    .src2   (req_src2),
    .hit    (sc_hit),
    .result (sc_result)
  );

  assign accept         = (state_q == S_IDLE) & req_valid & ~flush;
  assign fast_done      = FAST_PATH & sc_hit;
  assign is_div_q       = op_q[2];
  assign unit_ready     = is_div_q ? div_ready : mul_ready;
  assign unit_out_valid = is_div_q ? div_out_valid : mul_out_valid;
  assign capture        = (state_q == S_WAIT) & unit_out_valid & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = fast_done ? S_DONE : S_ISSUE;
      S_ISSUE: if (unit_ready) state_d = S_WAIT;
      S_WAIT:  if (unit_out_valid) state_d = S_DONE;
      S_DONE:  if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Flush overrides every transition, including a DONE handshake.
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= '0;
      w_q         <= 1'b0;
      src1_q      <= '0;
      src2_q      <= '0;
      resp_data_q <= '0;
    end else if (accept) begin
      op_q   <= req_op;
      w_q    <= req_w;
      src1_q <= req_src1;
      src2_q <= req_src2;
      if (fast_done) resp_data_q <= sc_result;
    end else if (capture) begin
      resp_data_q <= sel_result;
    end
  end

  always_comb begin
    if (is_div_q) begin
      raw_result = op_q[1] ? remainder : quotient;
    end else begin
      raw_result = (op_q[1:0] == 2'b00) ? mul_lo : mul_hi;
    end
    sel_result = w_q ? sext32(raw_result[31:0]) : raw_result;
  end

  always_comb begin
    unique case (op_q[1:0])
      2'b00, 2'b01: mul_signed = MS_SS;
      2'b10:        mul_signed = MS_SU;
      default:      mul_signed = MS_UU;
    endcase
  end

  // Valid is withdrawn in a flush cycle so no new op slips into a unit
  // that is being cancelled.
  assign mul_valid    = (state_q == S_ISSUE) & ~is_div_q & ~flush;
  assign div_valid    = (state_q == S_ISSUE) &  is_div_q & ~flush;
  assign mul_flush    = flush & ((state_q == S_ISSUE) | (state_q == S_WAIT)) & ~is_div_q;
  assign div_flush    = flush & ((state_q == S_ISSUE) | (state_q == S_WAIT)) &  is_div_q;
  assign mulw         = w_q;
  assign divw         = w_q;
  assign div_signed   = ~op_q[0];
  assign multiplicand = src1_q;
  assign multiplier   = src2_q;
  assign dividend     = src1_q;
  assign divisor      = src2_q;

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = (state_q == S_DONE);
  assign resp_data  = resp_data_q;

endmodule : muldiv_sched

// File: doc/muldiv_sched.md
Name: muldiv_sched

Overview:
- Sequencing controller between the EX stage and the shared iterative multiplier and divider units.
- Accepts one M-extension op at a time over a valid/ready request port, registers the operands and dispatches to the correct sub-unit with its handshake.
- Waits for that unit's out_valid, selects and sign-extends the result, and holds it on a valid/ready response port.
- Resolves RISC-V divide-by-zero and signed-overflow cases locally without engaging the divider, and supports pipeline flush.

Parameters:
- XLEN, 64, operand/result width.
- FAST_PATH, 1, when 1, divide-by-zero/overflow complete locally; when 0, they are sent to the divider.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  cancel in-flight op (branch/trap)
- req_valid  in  1  request valid
- req_ready  out  1  scheduler can accept
- req_op  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- req_w  in  1  32-bit (*W) variant
- req_src1  in  XLEN  rs1 operand (forwarded)
- req_src2  in  XLEN  rs2 operand (forwarded)
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer accepts result
- resp_data  out  XLEN  final result
- busy  out  1  state != IDLE
- mul_valid  out  1  to multiplier
- mul_ready  in  1  from multiplier
- mulw  out  1  to multiplier
- mul_signed  out  2  to multiplier
- multiplicand  out  XLEN  to multiplier
- multiplier  out  XLEN  to multiplier
- mul_flush  out  1  to multiplier
- mul_out_valid  in  1  from multiplier
- mul_hi  in  XLEN  from multiplier
- mul_lo  in  XLEN  from multiplier
- div_valid  out  1  to divider
- div_ready  in  1  from divider
- divw  out  1  to divider
- div_signed  out  1  to divider
- dividend  out  XLEN  to divider
- divisor  out  XLEN  to divider
- div_flush  out  1  to divider
- div_out_valid  in  1  from divider
- quotient  in  XLEN  from divider
- remainder  in  XLEN  from divider

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE.
- Reset values:
  - State is IDLE and all registers are cleared.
  - req_ready=1; busy, resp_valid, mul_valid, div_valid, mul_flush and div_flush are 0.
  - resp_data and all operand outputs are 0.
- IDLE:
  - req_ready=1.
  - On req_valid & !flush, latch op, w and both sources.
  - If FAST_PATH and the op is a divide special case, go to DONE. Otherwise go to ISSUE.
- ISSUE:
  - Assert mul_valid for op[2]=0, div_valid for op[2]=1, driven from registered operands.
  - Hold the valid until the unit's ready is sampled high in the same cycle, then go to WAIT. mul_valid/div_valid are low in the next cycle.
- WAIT:
  - On the selected unit's out_valid, capture the result into resp_data and go to DONE.
  - The other unit's out_valid is ignored.
- DONE:
  - resp_valid=1 with resp_data stable.
  - On resp_ready, go to IDLE. There is no same-cycle re-accept; a new request can be taken one cycle later.
- Latency:
  - Fast path: resp_valid 1 cycle after acceptance.
  - Normal path: 1 issue cycle plus unit latency plus 1 capture cycle.
- Sign controls:
  - mul_signed: MUL 11, MULH 11, MULHSU 10, MULHU 00.
  - div_signed = ~op[0].
  - mulw = divw = w.
- Result select:
  - MUL uses lo; MULH/MULHSU/MULHU use hi.
  - DIV/DIVU use quotient; REM/REMU use remainder.
  - If w, result = sign-extend of bits [31:0].
- Special cases (w uses [31:0] of the operands):
  - Divide by zero (src2==0): DIV/DIVU give all ones; REM/REMU give src1 (sign-extended if w).
  - Signed overflow (DIV/REM only, src1=most negative, src2=-1): DIV gives src1; REM gives 0.
  - W-variant overflow: DIVW gives 0xFFFFFFFF80000000.
- Flush:
  - In any state, next state is IDLE and resp_valid drops the next cycle.
  - If in ISSUE or WAIT, pulse mul_flush or div_flush (selected unit only) for 1 cycle.
  - Flush together with req_valid: the request is not accepted.
  - Flush in DONE together with resp_ready: the flush wins and no further response is produced.
- Stray out_valid in IDLE/ISSUE/DONE is ignored.
- rst mid-operation: immediate return to reset values; the sub-units are reset by the same rst.

Decomposition:
- Shared package/define file holds:
  - op encodings;
  - state encoding;
  - mul_signed constants.
- One sub-module, muldiv_special_case: combinational detection and result for divide-by-zero/overflow, 64- and 32-bit.
- The FSM and result select stay in the top.

Test Plan:
- MULHU w=0, src1=0xFFFFFFFFFFFFFFFF, src2=2; multiplier model with 5-cycle latency -> resp_data=0x1, mul_signed=00, resp_valid 7 cycles after acceptance.
- DIVW src1=0x00000000FFFFFFF9 (-7), src2=2 -> div_signed=1, divw=1, resp_data=0xFFFFFFFFFFFFFFFD.
- DIVU src2=0 with FAST_PATH=1 -> no div_valid, resp_data=0xFFFFFFFFFFFFFFFF one cycle after accept; REM src1=0x1234, src2=0 -> 0x1234.
- REM src1=0x8000000000000000, src2=0xFFFFFFFFFFFFFFFF -> resp_data=0, no divider engagement.
- DIV with divider mid-WAIT plus flush pulse -> div_flush one cycle, state IDLE, resp_valid never asserted, later MUL 3*4 returns 12.
- Backpressure: resp_ready low for 4 cycles in DONE -> resp_data/resp_valid stable, req_ready=0 throughout, req_ready high one cycle after resp_ready.
